// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_pkg
// Description : Shared types and helpers for the clock divider controller:
//               the controller state encoding, the smallest legal divide
//               ratio and a legality check for requested ratios.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int MIN_DIV = 2;

  // A ratio is usable only if it yields at least one high and one low cycle
  // and fits the configured ceiling.
  function automatic logic div_legal(input int div, input int max_div);
    return (div >= MIN_DIV) && (div <= max_div);
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_ctrl_if
// Description : Configuration / status bundle of the clock divider controller.
//   en        : run (1) or gate low after the current period (0)
//   cfg_valid : new ratio offered            cfg_div : requested ratio
//   cfg_ready : ratio can be accepted        cfg_err : illegal ratio discarded
//   clk_out   : divided clock                cur_div : ratio in force
//   busy      : divider running or draining
//   master = configuration source, slave = clk_div_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface clk_div_ctrl_if #(
  parameter int DIV_W = 5
);
  logic             en;
  logic             cfg_valid;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;
  logic             clk_out;
  logic [DIV_W-1:0] cur_div;
  logic             busy;

  modport master (
    output en, cfg_valid, cfg_div,
    input  cfg_ready, cfg_err, clk_out, cur_div, busy
  );

  modport slave (
    input  en, cfg_valid, cfg_div,
    output cfg_ready, cfg_err, clk_out, cur_div, busy
  );
endinterface
`default_nettype wire

// File: rtl/clk_div_core.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_core
// Description : Divider datapath: period counter, ratio register, posedge and
//               negedge phase flops and the glitch-free output OR.
//   clk_in, rst_n : source clock, async active-low reset
//   run           : divider is active in the coming cycle
//   load/load_div : swap in a new ratio at this edge (caller guarantees the
//                   edge is a period boundary or the divider is idle)
//   boundary      : current cycle is the last one of the period
//   clk_out       : divided clock        cur_div : ratio in force
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int MAX_DIV   = 16,
  parameter int DIV_W     = $clog2(MAX_DIV + 1),
  parameter int RESET_DIV = 3
) (
  input  wire logic             clk_in,
  input  wire logic             rst_n,
  input  wire logic             run,
  input  wire logic             load,
  input  wire logic [DIV_W-1:0] load_div,
  output logic                  boundary,
  output logic                  clk_out,
  output logic [DIV_W-1:0]      cur_div
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div;
  logic             r_active;
  logic             r_pos;
  logic             r_neg;
  logic [DIV_W-1:0] w_cnt_nxt;
  logic [DIV_W-1:0] w_div_nxt;
  logic             w_pos_nxt;

  assign boundary = r_active && (r_cnt == r_div - 1'b1);

  always_comb begin
    w_div_nxt = load ? load_div : r_div;
    w_cnt_nxt = '0;
    // The first active cycle after idle is count 0, so the high phase begins
    // on the very edge that starts the divider.
    if (run && r_active && !boundary && !load) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
    w_pos_nxt = run && (w_cnt_nxt < (w_div_nxt >> 1));
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_div    <= DIV_W'(RESET_DIV);
      r_active <= 1'b0;
      r_pos    <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_div    <= w_div_nxt;
      r_active <= run;
      r_pos    <= w_pos_nxt;
    end
  end

  // Half-cycle stretch for odd ratios. It is always low when the ratio
  // changes (the last cycle of every period is low), so r_div[0] switching
  // at a boundary cannot glitch the OR.
  always_ff @(negedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_neg <= 1'b0;
    end else begin
      r_neg <= r_pos;
    end
  end

  assign clk_out = r_pos | (r_neg & r_div[0]);
  assign cur_div = r_div;

endmodule
`default_nettype wire

// File: rtl/clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_ctrl
// Description : Runtime-reconfigurable glitch-free clock divider controller.
//               Accepts a ratio over valid/ready, defers it to a period
//               boundary (or applies it at once while idle) and gates the
//               divided clock cleanly with en.
//   clk_in, rst_n : source clock, async active-low reset
//   bus           : configuration / status bundle (slave side)
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int MAX_DIV   = 16,
  parameter int DIV_W     = $clog2(MAX_DIV + 1),
  parameter int RESET_DIV = 3
) (
  input wire logic      clk_in,
  input wire logic      rst_n,
  clk_div_ctrl_if.slave bus
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_pend;
  logic [DIV_W-1:0] r_pend_div;
  logic             r_err;
  logic             w_xfer;
  logic             w_legal;
  logic             w_load;
  logic             w_run;
  logic             w_boundary;

  assign w_xfer  = bus.cfg_valid && !r_pend;
  assign w_legal = div_legal(32'(bus.cfg_div), MAX_DIV);
  // A ratio accepted on a boundary edge sets r_pend only after that edge,
  // so it waits for the following boundary.
  assign w_load  = r_pend && ((r_state == IDLE) || w_boundary);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (bus.en) w_state_nxt = RUN;
      RUN:     if (!bus.en) w_state_nxt = DRAIN;
      DRAIN: begin
        if (bus.en)          w_state_nxt = RUN;
        else if (w_boundary) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    w_run = (w_state_nxt != IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pend     <= 1'b0;
      r_pend_div <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_xfer && !w_legal;
      if (w_load) begin
        r_pend <= 1'b0;
      end else if (w_xfer && w_legal) begin
        r_pend     <= 1'b1;
        r_pend_div <= bus.cfg_div;
      end
    end
  end

  clk_div_core #(
    .MAX_DIV   (MAX_DIV),
    .DIV_W     (DIV_W),
    .RESET_DIV (RESET_DIV)
  ) u_core (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .run      (w_run),
    .load     (w_load),
    .load_div (r_pend_div),
    .boundary (w_boundary),
    .clk_out  (bus.clk_out),
    .cur_div  (bus.cur_div)
  );

  assign bus.cfg_ready = !r_pend;
  assign bus.cfg_err   = r_err;
  assign bus.busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_div_ctrl
// Description : Self-checking bench for clk_div_ctrl: directed vector table,
//               hand-written corner sequences and randomized traffic compared
//               against a period/half-slot reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_ctrl;

  localparam int MAX_DIV   = 16;
  localparam int DIV_W     = 5;
  localparam int RESET_DIV = 3;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  always #5 clk_in = ~clk_in;

  clk_div_ctrl_if #(.DIV_W(DIV_W)) bus ();

  clk_div_ctrl #(
    .MAX_DIV   (MAX_DIV),
    .DIV_W     (DIV_W),
    .RESET_DIV (RESET_DIV)
  ) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: activity flag, position within the current period,
  // ratio in force and the pending request.
  int m_mode;      // 0 idle, 1 run, 2 drain
  int m_pos;
  int m_div;
  int m_pend;
  int m_pend_div;
  int m_err;
  logic s_clk_first;
  logic s_clk_second;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_mode = 0; m_pos = 0; m_div = RESET_DIV;
    m_pend = 0; m_pend_div = 0; m_err = 0;
  endtask

  // Clock is high for the first N half-cycles of each N-cycle period.
  function automatic int exp_clk(input int half);
    return ((m_mode != 0) && (2 * m_pos + half < m_div)) ? 1 : 0;
  endfunction

  task automatic model_edge();
    int  nmode;
    bit  bnd;
    bit  apply;
    bit  xfer;
    bit  legal;
    xfer  = bus.cfg_valid && (m_pend == 0);
    legal = (int'(bus.cfg_div) >= 2) && (int'(bus.cfg_div) <= MAX_DIV);
    bnd   = (m_mode != 0) && (m_pos == m_div - 1);
    apply = (m_pend != 0) && ((m_mode == 0) || bnd);
    nmode = m_mode;
    if (m_mode == 0)      nmode = bus.en ? 1 : 0;
    else if (m_mode == 1) nmode = bus.en ? 1 : 2;
    else                  nmode = bus.en ? 1 : (bnd ? 0 : 2);
    if (nmode == 0 || m_mode == 0 || bnd) m_pos = 0;
    else                                  m_pos = m_pos + 1;
    if (apply) begin
      m_div  = m_pend_div;
      m_pend = 0;
    end
    if (xfer && legal) begin
      m_pend     = 1;
      m_pend_div = int'(bus.cfg_div);
    end
    m_err  = (xfer && !legal) ? 1 : 0;
    m_mode = nmode;
  endtask

  // One clk_in cycle: model advances at the edge, both halves are checked.
  task automatic cycle();
    @(posedge clk_in);
    model_edge();
    #1;
    s_clk_first = bus.clk_out;
    chk("clk_out_first_half", bus.clk_out, exp_clk(0));
    chk("cur_div", bus.cur_div, m_div);
    chk("cfg_ready", bus.cfg_ready, (m_pend == 0) ? 1 : 0);
    chk("cfg_err", bus.cfg_err, m_err);
    chk("busy", bus.busy, (m_mode != 0) ? 1 : 0);
    @(negedge clk_in);
    #1;
    s_clk_second = bus.clk_out;
    chk("clk_out_second_half", bus.clk_out, exp_clk(1));
  endtask

  task automatic drive(input logic en, input logic v, input int d);
    bus.en        = en;
    bus.cfg_valid = v;
    bus.cfg_div   = DIV_W'(d);
  endtask

  typedef struct {
    logic en;
    logic v;
    int   d;
    int   e_cur;
    logic e_rdy;
    logic e_err;
    logic e_busy;
    logic e_clk;
  } vec_t;

  vec_t tbl[15];

  initial begin
    // en  v  div cur rdy err busy clk(first half)
    tbl[0]  = '{1'b0, 1'b0,  0, 3, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1,  2, 3, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0,  0, 2, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1,  1, 2, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 17, 2, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0,  0, 2, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1,  3, 2, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1,  5, 3, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0,  0, 3, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 1'b0,  0, 3, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 1'b0,  0, 3, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0,  0, 3, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 1'b0,  0, 3, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 1'b0,  0, 3, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b0,  0, 3, 1'b1, 1'b0, 1'b0, 1'b0};

    drive(1'b0, 1'b0, 0);
    m_reset();
    repeat (2) @(negedge clk_in);
    #1;
    chk("reset_clk_out", bus.clk_out, 0);
    chk("reset_cur_div", bus.cur_div, RESET_DIV);
    chk("reset_cfg_ready", bus.cfg_ready, 1);
    chk("reset_cfg_err", bus.cfg_err, 0);
    chk("reset_busy", bus.busy, 0);
    rst_n = 1'b1;

    // Directed table: idle config, illegal ratios, ignored offer while not
    // ready, start at N=3, then gate off through drain.
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].en, tbl[i].v, tbl[i].d);
      cycle();
      chk($sformatf("tbl%0d_cur_div", i), bus.cur_div, tbl[i].e_cur);
      chk($sformatf("tbl%0d_cfg_ready", i), bus.cfg_ready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_cfg_err", i), bus.cfg_err, tbl[i].e_err);
      chk($sformatf("tbl%0d_busy", i), bus.busy, tbl[i].e_busy);
      chk($sformatf("tbl%0d_clk", i), s_clk_first, tbl[i].e_clk);
    end

    // Reconfigure in RUN: N=4, then 7 offered mid-period.
    drive(1'b0, 1'b1, 4); cycle();
    drive(1'b0, 1'b0, 0); cycle();
    drive(1'b1, 1'b0, 0); cycle(); cycle();
    drive(1'b1, 1'b1, 7); cycle();
    drive(1'b1, 1'b0, 0);
    repeat (20) cycle();
    chk("reconfig_cur_div", bus.cur_div, 7);

    // Gating at N=6 with re-enable during drain: busy must stay high.
    drive(1'b1, 1'b1, 6); cycle();
    drive(1'b1, 1'b0, 0);
    repeat (8) cycle();
    while (m_pos != m_div - 1) cycle();
    drive(1'b0, 1'b0, 0); cycle(); cycle();
    drive(1'b1, 1'b0, 0);
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("drain_reenable_busy", bus.busy, 1);
    end
    // Full drain this time.
    while (m_pos != m_div - 1) cycle();
    drive(1'b0, 1'b0, 0);
    repeat (8) cycle();
    chk("drained_busy", bus.busy, 0);

    // Async reset during a high phase at N=5.
    drive(1'b0, 1'b1, 5); cycle();
    drive(1'b1, 1'b0, 0);
    repeat (6) cycle();
    while (m_pos != 0) cycle();
    @(posedge clk_in);
    model_edge();
    #2;
    chk("pre_reset_clk_high", bus.clk_out, 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_clk_out", bus.clk_out, 0);
    chk("async_reset_cur_div", bus.cur_div, RESET_DIV);
    chk("async_reset_cfg_ready", bus.cfg_ready, 1);
    chk("async_reset_busy", bus.busy, 0);
    m_reset();
    drive(1'b0, 1'b0, 0);
    @(negedge clk_in);
    #1;
    rst_n = 1'b1;
    cycle();
    chk("post_reset_idle", bus.busy, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      logic en_r;
      int   d;
      en_r = bus.en;
      if ($urandom_range(0, 15) == 0) en_r = ~en_r;
      if ($urandom_range(0, 7) == 0) d = int'($urandom_range(0, 31));
      else                           d = int'($urandom_range(2, MAX_DIV));
      drive(en_r, ($urandom_range(0, 3) == 0), d);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
